// File: rtl/ysyx_23060187_pkg.sv
// Shared definitions for the fetch path: responder FSM encoding, reset PC,
// canonical nop, and the address helpers used by the instruction responder.
package ysyx_23060187_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } imem_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    // Word offset from the store base; callers truncate to the array index width.
    function automatic logic [31:0] word_off(input logic [31:0] addr, input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

    // Misaligned or outside [base, base+span): span is the store size in bytes.
    function automatic logic addr_fault(input logic [31:0] addr, input logic [31:0] base,
                                        input logic [32:0] span);
        logic [32:0] lim;
        lim = {1'b0, base} + span;
        return (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, addr} >= lim);
    endfunction

endpackage

// File: rtl/ysyx_23060187_imem_array.sv
// DEPTH x 32 instruction store: synchronous write, registered read,
// write-first on a same-index collision. rkill substitutes a nop on the read.
module ysyx_23060187_imem_array
    import ysyx_23060187_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic          rkill,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_d, rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            if (rkill)                      rdata_d = NOP_INST;
            else if (we && waddr == raddr)  rdata_d = wdata;
            else                            rdata_d = mem[raddr];
        end
    end

    // Read register doubles as the response word, so it resets with the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdata_q <= '0;
        else      rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ysyx_23060187_imem_resp.sv
// Handshaked instruction responder with fixed latency LAT and a preload port.
// Define YSYX_23060187_IMEM_CHK_EN to fault misaligned/out-of-range fetches.
module ysyx_23060187_imem_resp
    import ysyx_23060187_pkg::*;
#(
    parameter int          DEPTH = 4096,
    parameter logic [31:0] BASE  = RESET_PC,
    parameter int          LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_inst,
    output logic        rsp_err,
    input  logic        rsp_ready,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    imem_state_e   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic          err_q, err_d;
    logic          vld_q, vld_d;
    logic          req_fault, rd_en, rd_kill;
    logic [AW-1:0] rd_idx, wr_idx;

`ifdef YSYX_23060187_IMEM_CHK_EN
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;
    assign req_fault = addr_fault(req_addr, BASE, SPAN);
    assign rsp_err   = err_q;
`else
    assign req_fault = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    assign wr_idx    = AW'(word_off(ld_addr, BASE));
    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = vld_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        err_d   = err_q;
        vld_d   = vld_q;
        rd_en   = 1'b0;
        rd_kill = err_q;
        rd_idx  = AW'(word_off(addr_q, BASE));
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    err_d  = req_fault;
                    // LAT==1 reads straight from the request so RESP follows the handshake.
                    if (LAT_M1 == 4'd0) begin
                        state_d = S_RESP;
                        vld_d   = 1'b1;
                        rd_en   = 1'b1;
                        rd_kill = req_fault;
                        rd_idx  = AW'(word_off(req_addr, BASE));
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0) begin
                    state_d = S_RESP;
                    vld_d   = 1'b1;
                    rd_en   = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    vld_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
        end
    end

    ysyx_23060187_imem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (ld_en),
        .waddr (wr_idx),
        .wdata (ld_data),
        .re    (rd_en),
        .rkill (rd_kill),
        .raddr (rd_idx),
        .rdata (rsp_inst)
    );

endmodule

// File: tb/tb_ysyx_23060187_imem_resp.sv
// Scoreboard bench: u_dut0 runs LAT=2, u_dut1 runs LAT=1; both share the preload port.
module tb_ysyx_23060187_imem_resp;
    import ysyx_23060187_pkg::*;

    localparam logic [31:0] B     = 32'h8000_0000;
    localparam logic [31:0] WLAST = 32'hCAFE_F00D;
`ifdef YSYX_23060187_IMEM_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_err, rsp_ready;
    logic [31:0] req_addr [2];
    logic [31:0] rsp_inst [2];
    logic        ld_en;
    logic [31:0] ld_addr, ld_data;

    typedef struct { logic [31:0] inst; logic err; int hs; } exp_t;
    exp_t        sb [2][$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] w [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ysyx_23060187_imem_resp #(.DEPTH(4096), .BASE(B), .LAT(2)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_addr(req_addr[0]),
        .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_inst(rsp_inst[0]),
        .rsp_err(rsp_err[0]), .rsp_ready(rsp_ready[0]), .ld_en(ld_en),
        .ld_addr(ld_addr), .ld_data(ld_data));

    ysyx_23060187_imem_resp #(.DEPTH(4096), .BASE(B), .LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_addr(req_addr[1]),
        .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_inst(rsp_inst[1]),
        .rsp_err(rsp_err[1]), .rsp_ready(rsp_ready[1]), .ld_en(ld_en),
        .ld_addr(ld_addr), .ld_data(ld_data));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic do_req(input int k, input logic [31:0] a, input logic [31:0] inst,
                          input logic err, input bit push, output int hs);
        int t = 0;
        hs = -1;
        while (!req_ready[k] && t < 100) begin @(negedge clk); t++; end
        if (!req_ready[k]) begin
            check($sformatf("req_ready_timeout%0d", k), {31'b0, req_ready[k]}, 32'd1);
            return;
        end
        req_valid[k] = 1'b1; req_addr[k] = a;
        hs = cyc + 1;
        if (push) sb[k].push_back('{inst: inst, err: err, hs: hs});
        @(negedge clk);
        req_valid[k] = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb[0].size() != 0 || sb[1].size() != 0) && t < 60) begin @(negedge clk); t++; end
        check("drain", sb[0].size() + sb[1].size(), 32'd0);
    endtask

    // Monitor: latency on the rising edge of rsp_valid, data on each response handshake.
    initial begin
        logic [1:0] prev;
        exp_t e;
        prev = '0;
        forever begin
            @(negedge clk); #1;
            if (!rst) prev = '0;
            else for (int k = 0; k < 2; k++) begin
                if (rsp_valid[k] && !prev[k]) begin
                    if (sb[k].size() == 0)
                        check($sformatf("unexpected_rsp%0d", k), {31'b0, rsp_valid[k]}, 32'd0);
                    else
                        check($sformatf("latency%0d", k), cyc + 1 - sb[k][0].hs, (k == 0) ? 32'd2 : 32'd1);
                end
                if (rsp_valid[k] && rsp_ready[k] && sb[k].size() != 0) begin
                    e = sb[k].pop_front();
                    check($sformatf("inst%0d", k), rsp_inst[k], e.inst);
                    check($sformatf("err%0d", k), {31'b0, rsp_err[k]}, {31'b0, e.err});
                end
                prev[k] = rsp_valid[k];
            end
        end
    end

    initial begin
        logic [31:0] fa   [4];
        logic [31:0] fi   [4];
        logic        fe   [4];
        int          hs, hs_prev;
        req_valid = '0; rsp_ready = 2'b11; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        req_addr[0] = '0; req_addr[1] = '0;
        w[0] = 32'h0050_0093;
        for (int i = 1; i < 8; i++) w[i] = 32'h1000_0000 + 32'(i) * 32'h0101;

        repeat (3) @(negedge clk);
        check("rst_rsp_valid", {30'b0, rsp_valid}, 32'd0);
        check("rst_rsp_inst", rsp_inst[0], 32'h0);
        check("rst_rsp_err", {30'b0, rsp_err}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_req_ready", {30'b0, req_ready}, 32'd3);

        for (int i = 0; i < 8; i++) preload(B + 32'(i) * 4, w[i]);
        preload(B + 32'd400, 32'h1111_1111);
        preload(B + 32'h3FFC, WLAST);

        // Basic fetch, LAT=2
        do_req(0, B, w[0], 1'b0, 1'b1, hs);
        drain();

        // Backpressure: response held while consumer stalls
        rsp_ready[0] = 1'b0;
        do_req(0, B + 32'd20, w[5], 1'b0, 1'b1, hs);
        for (int t = 0; t < 20 && !rsp_valid[0]; t++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", {31'b0, rsp_valid[0]}, 32'd1);
            check("stall_inst", rsp_inst[0], w[5]);
            check("stall_req_ready", {31'b0, req_ready[0]}, 32'd0);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        check("post_stall_req_ready", {31'b0, req_ready[0]}, 32'd1);
        check("post_stall_valid", {31'b0, rsp_valid[0]}, 32'd0);

        // Faulting / wrapping addresses, last in-range word
        fa[0] = B + 32'd2;      fa[1] = 32'h7FFF_FFFC; fa[2] = B + 32'h4000; fa[3] = B + 32'h3FFC;
        fi[0] = CHK ? NOP_INST : w[0];
        fi[1] = CHK ? NOP_INST : WLAST;
        fi[2] = CHK ? NOP_INST : w[0];
        fi[3] = WLAST;
        fe[0] = CHK; fe[1] = CHK; fe[2] = CHK; fe[3] = 1'b0;
        for (int i = 0; i < 4; i++) do_req(0, fa[i], fi[i], fe[i], 1'b1, hs);
        drain();

        // Preload hits the latched word in the cycle the WAIT read fires
        do_req(0, B + 32'd400, 32'hDEAD_BEEF, 1'b0, 1'b1, hs);
        ld_en = 1'b1; ld_addr = B + 32'd400; ld_data = 32'hDEAD_BEEF;
        @(negedge clk);
        ld_en = 1'b0;
        drain();

        // Reset mid-WAIT drops the transaction
        do_req(0, B + 32'd4, w[1], 1'b0, 1'b0, hs);
        rst = 1'b0;
        #2;
        check("rst_wait_valid", {31'b0, rsp_valid[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst_valid", {31'b0, rsp_valid[0]}, 32'd0);
        end
        check("post_rst_req_ready", {31'b0, req_ready[0]}, 32'd1);
        check("post_rst_inst", rsp_inst[0], 32'h0);

        // LAT=1 streaming: one response every two cycles
        hs_prev = -1;
        for (int i = 0; i < 8; i++) begin
            do_req(1, B + 32'(i) * 4, w[i], 1'b0, 1'b1, hs);
            if (i > 0) check("lat1_spacing", hs - hs_prev, 32'd2);
            hs_prev = hs;
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ysyx_23060187_imem_resp.md
# ysyx_23060187_imem_resp

Instruction-memory responder at the far end of the fetch path: accepts one fetch request (PC) at a time over a valid/ready handshake, waits a fixed programmable latency, and returns the 32-bit instruction word over a second valid/ready handshake. Sits between the PC register/fetch stage and a word-addressed instruction store. It is preloadable through a write port for simulation and boot. It lets the core move from single-cycle fetch to handshaked, multi-cycle fetch.

## Interface
- `DEPTH`, 4096, instruction words held (power of two)
- `BASE`, 32'h80000000, byte address of word 0
- `LAT`, 2, cycles from request acceptance to `rsp_valid` (1..15)
- `clk` in 1 system clock, rising edge
- `rst` in 1 reset, asynchronous, active-low
- `req_valid` in 1 fetch request present
- `req_addr` in 32 fetch byte address (PC)
- `req_ready` out 1 responder can accept a request
- `rsp_valid` out 1 instruction word valid
- `rsp_inst` out 32 instruction word
- `rsp_err` out 1 access fault, valid with `rsp_valid`
- `rsp_ready` in 1 consumer takes response
- `ld_en` in 1 preload write strobe
- `ld_addr` in 32 preload byte address
- `ld_data` in 32 preload word

## Operation
- States: IDLE, WAIT, RESP. One request outstanding at most.
- IDLE: `req_ready`=1. On `req_valid`&`req_ready`: latch `req_addr`, load latency counter with `LAT-1`, go to WAIT. If `LAT-1`=0, go directly to RESP.
- WAIT: `req_ready`=0. Counter decrements each cycle. At 0: read word at index `(addr-BASE)>>2` modulo `DEPTH`, register it into `rsp_inst`, and go to RESP.
- RESP: `rsp_valid`=1. `rsp_inst` and `rsp_err` hold stable until `rsp_valid`&`rsp_ready`. Then go to IDLE. No back-to-back bypass: the next request is accepted only in IDLE.
- Preload: a write with `ld_en`=1 stores `ld_data` at index `(ld_addr-BASE)>>2` modulo `DEPTH` on the rising edge, in any state. If the write targets the latched address in the same cycle as the WAIT read, the read returns the new data.
- Index arithmetic is 32-bit unsigned subtraction. The result is truncated to log2(DEPTH) bits after `>>2`, so addresses wrap.

## Timing
- Reset values (async, while `rst`=0): state IDLE, `req_ready`=1 after release, `rsp_valid`=0, `rsp_inst`=32'h0, `rsp_err`=0, counter 0. Memory contents are not reset.
- Reset asserted mid-WAIT or mid-RESP drops the transaction. No response is issued after release.
- Latency: request handshake at edge N gives `rsp_valid` high from edge N+`LAT`.
- Throughput: at best one instruction per `LAT`+1 cycles, with `rsp_ready` held high.
- `req_ready` is a registered-state decode only, with no combinational path from `req_valid`. `rsp_valid`, `rsp_inst` and `rsp_err` come straight from flops.

## Configuration
- `YSYX_23060187_IMEM_CHK_EN` defined: the access is checked at latch time. The fault condition is `req_addr[1:0]`≠0, or `req_addr`<`BASE`, or `req_addr`≥`BASE+4*DEPTH`. On a fault the response returns `rsp_err`=1 and `rsp_inst`=32'h00000013 (nop), with the same latency.
- `YSYX_23060187_IMEM_CHK_EN` undefined: no checking. `rsp_err` is tied 0. Address bits [1:0] are ignored and the index wraps.

## Structure
- The shared package `ysyx_23060187_pkg` holds:
  - the state encoding typedef (IDLE/WAIT/RESP)
  - `NOP_INST` = 32'h00000013
  - `RESET_PC` = 32'h80000000, which is also used by the PC register.
- One sub-module, `ysyx_23060187_imem_array`: a synchronous-write, synchronous-read DEPTH×32 array. It has its own write port and read port, with write-first behaviour on a same-address collision.

## Test plan
- Preload 0x80000000←32'h00500093. Then request 0x80000000 with `LAT`=2 and `rsp_ready`=1. Expect `rsp_valid` 2 cycles after the handshake, `rsp_inst`=32'h00500093, `rsp_err`=0.
- Issue a request and hold `rsp_ready`=0 for 5 cycles. Expect `rsp_valid`/`rsp_inst` stable and `req_ready`=0 throughout. After `rsp_ready` pulses, expect `req_ready`=1 on the next cycle.
- With CHK_EN, request 0x80000002, then 0x7FFFFFFC. Expect `rsp_err`=1 and `rsp_inst`=32'h00000013 for each. Without CHK_EN, 0x80000002 returns word 0.
- Write `ld_data`=32'hDEADBEEF to the latched address on the same cycle the WAIT counter reaches 0. Expect `rsp_inst`=32'hDEADBEEF.
- Drive `rst` low in WAIT, release it, and idle 10 cycles. Expect `rsp_valid` to stay 0 and `req_ready`=1 after release.
- Run 8 sequential requests 0x80000000..0x8000001C with `LAT`=1. Expect each preloaded word in order, at one response per 2 cycles.
